column_scheduler: RTL and testbench
===================================

COLUMN_SCHEDULER -- requirements
Module: column_scheduler

Interface
REQ-001 SHALL have parameter N_PP, default 16: number of partial products (column height).
REQ-002 SHALL have parameter WIDTH, default 64: partial-product width (number of columns).
REQ-003 SHALL have parameter CW, default 14: width of the slice carry chain.
REQ-004 SHALL be clocked by a single clock and reset by an asynchronous, active-high reset; no other clock or reset exists.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 in_valid  input  1  partial-product matrix valid.
REQ-008 in_ready  output  1  scheduler can accept a matrix.
REQ-009 pp  input  N_PP*WIDTH  partial products; P_k = pp[WIDTH*k+WIDTH-1 : WIDTH*k].
REQ-010 slice_en  output  1  column presented to the shared compressor slice is valid.
REQ-011 slice_col  output  N_PP  current column: {P_0[i], P_1[i], ..., P_15[i]}, with P_0 at the MSB.
REQ-012 slice_cin  output  CW  carry-in to the slice (the previous column's carry-out).
REQ-013 slice_s  input  1  slice sum bit (combinational from slice_col and slice_cin).
REQ-014 slice_c  input  1  slice carry bit, weight 2^(i+1).
REQ-015 slice_cout  input  CW  slice carry-out to the next column.
REQ-016 out_valid  output  1  result vectors valid.
REQ-017 out_ready  input  1  consumer accepts the result.
REQ-018 sum_vec  output  WIDTH  collected sum bits.
REQ-019 carry_vec  output  WIDTH  collected carry bits, already shifted to their own weight.
REQ-020 busy  output  1  high when the state is not IDLE.

Function
REQ-021 SHALL implement an FSM with three states: IDLE, RUN and DONE.
REQ-022 IDLE: in_ready=1; when in_valid=1, SHALL register pp, clear col_idx to 0, the carry register and both result vectors, and go to RUN.
REQ-023 RUN: slice_en=1; slice_col SHALL be bit col_idx of the registered matrix; slice_cin SHALL be the carry register.
REQ-024 Each RUN edge SHALL do all of the following:
- sum_vec[col_idx] <= slice_s;
- carry_vec[col_idx+1] <= slice_c when col_idx < WIDTH-1, and slice_c is discarded when col_idx = WIDTH-1;
- the carry register <= slice_cout;
- col_idx increments.
REQ-025 When col_idx = WIDTH-1, SHALL go to DONE; the final slice_cout is discarded (result is modulo 2^WIDTH).
REQ-026 carry_vec[0] SHALL always be 0.
REQ-027 DONE: out_valid=1 with sum_vec and carry_vec stable; when out_ready=1, SHALL go to IDLE.
REQ-028 Latency SHALL be exactly WIDTH edges from the accepting edge to out_valid high (64 by default).
REQ-029 out_valid SHALL hold, with unchanged data, for as long as out_ready=0.
REQ-030 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored without side effects.
REQ-031 There SHALL be no same-cycle pass-through: a new matrix is accepted only in IDLE, one cycle after the DONE handshake.
REQ-032 slice_en SHALL be 0, and slice_col and slice_cin SHALL be 0, outside RUN.
REQ-033 col_idx SHALL be wide enough for WIDTH-1, SHALL NOT wrap during RUN, and SHALL be cleared on acceptance.

Reset
REQ-034 Asserting rst SHALL immediately force IDLE and clear the following to 0: in-flight registered pp, col_idx, carry register, sum_vec, carry_vec.
REQ-035 Reset output values SHALL be: in_ready=1, out_valid=0, busy=0, slice_en=0, slice_col=0, slice_cin=0, sum_vec=0, carry_vec=0.
REQ-036 Reset during RUN or DONE SHALL abort the operation with no out_valid pulse; the first post-reset acceptance SHALL behave as a fresh operation.

Verification (the bench supplies a behavioural 16-input compressor slice model)
REQ-037 pp=0, in_valid for 1 cycle, out_ready=1 -> out_valid on the 64th edge after acceptance; sum_vec=0, carry_vec=0.
REQ-038 P_15=64'h1, all other P_k=0 -> on the first RUN cycle slice_col=16'h0001; result sum_vec+carry_vec=64'h1.
REQ-039 All P_k=64'hFFFF_FFFF_FFFF_FFFF -> every slice_col=16'hFFFF; (sum_vec+carry_vec) mod 2^64 = 16*(2^64-1) mod 2^64 = 64'hFFFF_FFFF_FFFF_FFF0.
REQ-040 out_ready held 0 for 10 cycles in DONE -> out_valid and vectors stable; in_valid pulses meanwhile are ignored (in_ready=0); the handshake then returns to IDLE.
REQ-041 rst asserted at col_idx=30 -> outputs take their reset values asynchronously; the next matrix completes correctly after 64 edges.
REQ-042 Two back-to-back matrices, out_ready=1 -> second acceptance 1 cycle after the first DONE handshake; both results match the reference model sum.

Source files
------------

// File: rtl/column_scheduler.sv
// column_scheduler
//   Serialises a partial-product matrix through one shared column-compressor
//   slice. An accepted matrix is walked column by column, LSB first. For each
//   column the slice returns a sum bit, which lands at the column's own
//   weight, and a carry bit, which lands one column higher. A carry-out bus
//   from the slice feeds back as the next column's carry-in. After WIDTH
//   columns the scheduler presents sum_vec and carry_vec. Their sum, modulo
//   2^WIDTH, equals the sum of all partial products.
//
// Ports
//   clk, rst      clock and asynchronous active-high reset
//   in_valid      partial-product matrix offered (accepted only while in_ready)
//   in_ready      high in IDLE
//   pp            N_PP words of WIDTH bits; word k is P_k
//   slice_en      a column is being presented to the slice (RUN only)
//   slice_col     current column, P_0 bit at the MSB
//   slice_cin     carry-in to the slice (previous column's carry-out)
//   slice_s       sum bit returned by the slice
//   slice_c       carry bit returned by the slice, weight of the next column
//   slice_cout    carry-out from the slice toward the next column
//   out_valid     result vectors valid (DONE)
//   out_ready     consumer accepts the result
//   sum_vec       collected sum bits
//   carry_vec     collected carry bits at their own weight (bit 0 always 0)
//   busy          high whenever the scheduler is not IDLE

module column_scheduler #(
  parameter int N_PP  = 16,
  parameter int WIDTH = 64,
  parameter int CW    = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_PP*WIDTH-1:0] pp,
  output logic                  slice_en,
  output logic [N_PP-1:0]       slice_col,
  output logic [CW-1:0]         slice_cin,
  input  logic                  slice_s,
  input  logic                  slice_c,
  input  logic [CW-1:0]         slice_cout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      sum_vec,
  output logic [WIDTH-1:0]      carry_vec,
  output logic                  busy
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_COL = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [N_PP*WIDTH-1:0]   pp_reg;
  logic [IW-1:0]           col_idx;
  logic [CW-1:0]           carry_reg;
  logic                    last_col;
  logic [WIDTH-1:0]        pp_word [N_PP];
  logic [N_PP-1:0]         col_bits;

  assign last_col = (col_idx == LAST_COL);

  // The registered matrix is split into words so that each column bit can be
  // selected with an index of exactly the column-counter width.
  for (genvar k = 0; k < N_PP; k++) begin : g_col
    assign pp_word[k]          = pp_reg[WIDTH*k +: WIDTH];
    assign col_bits[N_PP-1-k]  = pp_word[k][col_idx];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake/slice outputs. The slice bus is forced to zero
  // outside RUN so that a stale column never reaches the shared slice.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    slice_en   = 1'b0;
    slice_col  = '0;
    slice_cin  = '0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        slice_en  = 1'b1;
        slice_col = col_bits;
        slice_cin = carry_reg;
        if (last_col) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath. On the last column the carry bit and the carry-out would have
  // weight 2^WIDTH. Both are dropped, so the result is modulo 2^WIDTH. Dropping
  // them also keeps col_idx from wrapping, and carry_vec[0] is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pp_reg    <= '0;
      col_idx   <= '0;
      carry_reg <= '0;
      sum_vec   <= '0;
      carry_vec <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            pp_reg    <= pp;
            col_idx   <= '0;
            carry_reg <= '0;
            sum_vec   <= '0;
            carry_vec <= '0;
          end
        end
        RUN: begin
          sum_vec[col_idx] <= slice_s;
          if (!last_col) begin
            carry_vec[col_idx + 1'b1] <= slice_c;
            carry_reg                 <= slice_cout;
            col_idx                   <= col_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_column_scheduler.sv
// tb_column_scheduler
//   Directed bench for column_scheduler with a behavioural 16-input compressor
//   slice. Each accepted matrix pushes its reference sum (the plain modulo
//   2^64 sum of its words) onto a scoreboard queue. The queue is popped when
//   the DUT presents its result.

module tb_column_scheduler;

  localparam int N_PP  = 16;
  localparam int WIDTH = 64;
  localparam int CW    = 14;
  localparam int MW    = N_PP * WIDTH;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [MW-1:0]     pp;
  logic              slice_en;
  logic [N_PP-1:0]   slice_col;
  logic [CW-1:0]     slice_cin;
  logic              slice_s;
  logic              slice_c;
  logic [CW-1:0]     slice_cout;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  sum_vec;
  logic [WIDTH-1:0]  carry_vec;
  logic              busy;

  int                n_compared   = 0;
  int                n_mismatched = 0;
  logic [WIDTH-1:0]  sb [$];
  logic [MW-1:0]     cur_matrix;
  logic [WIDTH-1:0]  discard;
  int                slice_v;

  always #5 clk = ~clk;

  column_scheduler #(.N_PP(N_PP), .WIDTH(WIDTH), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pp         (pp),
    .slice_en   (slice_en),
    .slice_col  (slice_col),
    .slice_cin  (slice_cin),
    .slice_s    (slice_s),
    .slice_c    (slice_c),
    .slice_cout (slice_cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum_vec    (sum_vec),
    .carry_vec  (carry_vec),
    .busy       (busy)
  );

  // Compressor slice model. The value v = popcount(column) + cin is split into
  // three parts: s at weight 2^i, c at weight 2^(i+1), and an even remainder
  // that leaves as cout, also at weight 2^(i+1). In total,
  // v = s + 2*c + 2*cout.
  always_comb begin
    slice_v    = $countones(slice_col) + int'(slice_cin);
    slice_s    = slice_v[0];
    slice_c    = slice_v[1];
    slice_cout = CW'((slice_v / 4) * 2);
  end

  function automatic logic [WIDTH-1:0] refSum(input logic [MW-1:0] m);
    logic [WIDTH-1:0] acc = '0;
    for (int k = 0; k < N_PP; k++) acc = acc + m[WIDTH*k +: WIDTH];
    return acc;
  endfunction

  function automatic logic [N_PP-1:0] colOf(input logic [MW-1:0] m, input int i);
    logic [N_PP-1:0] c = '0;
    for (int k = 0; k < N_PP; k++) c[N_PP-1-k] = m[WIDTH*k + i];
    return c;
  endfunction

  function automatic logic [MW-1:0] randMatrix();
    logic [MW-1:0] m = '0;
    for (int k = 0; k < MW/32; k++) m[32*k +: 32] = $urandom();
    return m;
  endfunction

  task automatic compare(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one matrix for a single cycle and record its expected result.
  task automatic applyStimulus(input logic [MW-1:0] m);
    int w = 0;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    compare("in_ready_before_accept", in_ready, 1);
    pp         = m;
    in_valid   = 1'b1;
    cur_matrix = m;
    sb.push_back(refSum(m));
    @(negedge clk);
    in_valid = 1'b0;
    compare("busy_after_accept", busy, 1);
  endtask

  // Follow the column walk, then check latency, the result, the hold
  // behaviour with a stalled consumer, and the return to IDLE.
  task automatic checkOutput(input int hold);
    int               n = 0;
    logic [WIDTH-1:0] exp;
    logic [WIDTH-1:0] s0;
    logic [WIDTH-1:0] c0;
    while (!out_valid && n < 200) begin
      if (n == 0) compare("slice_en_run", slice_en, 1);
      if (n < WIDTH) compare($sformatf("slice_col[%0d]", n), slice_col, colOf(cur_matrix, n));
      @(negedge clk);
      n++;
    end
    compare("latency", n, WIDTH);
    compare("scoreboard_depth", sb.size(), 1);
    exp = (sb.size() > 0) ? sb.pop_front() : '0;
    compare("result_sum", sum_vec + carry_vec, exp);
    compare("carry_vec_bit0", carry_vec[0], 0);
    compare("slice_en_done", slice_en, 0);
    compare("slice_col_done", slice_col, 0);
    compare("slice_cin_done", slice_cin, 0);
    s0 = sum_vec;
    c0 = carry_vec;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      pp       = randMatrix();
      compare("hold_out_valid", out_valid, 1);
      compare("hold_in_ready", in_ready, 0);
      compare("hold_sum_vec", sum_vec, s0);
      compare("hold_carry_vec", carry_vec, c0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (hold > 0) begin
      compare("hold_end_out_valid", out_valid, 1);
      compare("hold_end_sum_vec", sum_vec, s0);
      compare("hold_end_carry_vec", carry_vec, c0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    compare("idle_in_ready", in_ready, 1);
    compare("idle_out_valid", out_valid, 0);
    compare("idle_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [MW-1:0] m;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    pp        = '0;
    @(negedge clk);
    @(negedge clk);
    compare("reset_in_ready", in_ready, 1);
    compare("reset_out_valid", out_valid, 0);
    compare("reset_busy", busy, 0);
    compare("reset_slice_en", slice_en, 0);
    compare("reset_slice_col", slice_col, 0);
    compare("reset_slice_cin", slice_cin, 0);
    compare("reset_sum_vec", sum_vec, 0);
    compare("reset_carry_vec", carry_vec, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] zero matrix");
    applyStimulus('0);
    checkOutput(0);
    compare("zero_sum_vec", sum_vec, 0);
    compare("zero_carry_vec", carry_vec, 0);

    $display("[TB] single bit in P_15");
    m = '0;
    m[WIDTH*15] = 1'b1;
    applyStimulus(m);
    checkOutput(0);
    compare("p15_result", sum_vec + carry_vec, 64'h1);

    $display("[TB] all-ones matrix");
    m = '1;
    applyStimulus(m);
    checkOutput(0);
    compare("ones_result", sum_vec + carry_vec, 64'hFFFF_FFFF_FFFF_FFF0);

    $display("[TB] stalled consumer for 10 cycles");
    applyStimulus(randMatrix());
    checkOutput(10);

    $display("[TB] reset at column 30");
    m = randMatrix();
    applyStimulus(m);
    repeat (30) @(negedge clk);
    compare("pre_reset_col30", slice_col, colOf(m, 30));
    #2 rst = 1'b1;
    #1;
    compare("async_rst_in_ready", in_ready, 1);
    compare("async_rst_busy", busy, 0);
    compare("async_rst_slice_en", slice_en, 0);
    compare("async_rst_slice_col", slice_col, 0);
    compare("async_rst_slice_cin", slice_cin, 0);
    compare("async_rst_sum_vec", sum_vec, 0);
    compare("async_rst_carry_vec", carry_vec, 0);
    discard = sb.pop_back();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 70; i++) begin
      compare("no_valid_after_abort", out_valid, 0);
      @(negedge clk);
    end
    applyStimulus(randMatrix());
    checkOutput(0);

    $display("[TB] back-to-back matrices");
    applyStimulus(randMatrix());
    checkOutput(0);
    applyStimulus(randMatrix());
    checkOutput(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
